// File: rtl/engine_warn_pkg.sv
// Shared constants for the engine-warning controller: FSM state encoding,
// flag bit positions, default red mask and the severity classifier.
package engine_warn_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2,
    ST_HELD  = 2'd3
  } warn_state_e;

  typedef enum logic [1:0] {
    SEV_NONE    = 2'd0,
    SEV_CAUTION = 2'd1,
    SEV_RED     = 2'd2
  } sev_e;

  localparam int NUM_FLAGS              = 4;
  localparam int FLAG_OIL_TEMP_HIGH     = 0;
  localparam int FLAG_OIL_LOW           = 1;
  localparam int FLAG_COOLANT_TEMP_HIGH = 2;
  localparam int FLAG_COOLANT_LOW       = 3;
  localparam int NUM_INPUTS             = NUM_FLAGS + 1;  // sensors plus ack button
  localparam int IDX_ACK                = NUM_FLAGS;

  localparam logic [15:0] RED_MASK_DEFAULT = 16'hF0A8;

  // The mask is a 16-entry truth table indexed by the whole flag vector.
  function automatic sev_e classify(input logic [NUM_FLAGS-1:0] flags,
                                    input logic [15:0]          mask);
    if (mask[flags])     return SEV_RED;
    else if (flags != 0) return SEV_CAUTION;
    else                 return SEV_NONE;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced output
// follows the synchronised input only after DEBOUNCE_CYCLES consecutive mismatches.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d  = sync_q[1];
      else                                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/engine_warning_ctrl.sv
// Dashboard engine-warning controller: debounced sensors feed a severity FSM that
// drives the LEDs and a blinking alarm. Define FAULT_LOG_EN for the sticky fault log.
module engine_warning_ctrl
  import engine_warn_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES   = 1_000_000,
  parameter int          BLINK_HALF_PERIOD = 25_000_000,
  parameter logic [15:0] RED_MASK          = RED_MASK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coolant_low,
  input  logic       coolant_temp_high,
  input  logic       oil_low,
  input  logic       oil_temp_high,
  input  logic       ack_btn,
  output logic       led_green,
  output logic       led_yellow,
  output logic       led_red,
  output logic       alarm_blink,
  output logic [1:0] warn_state,
  output logic [3:0] flags_db,
  output logic [3:0] fault_log
);
  localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  logic [NUM_INPUTS-1:0] raw_vec, db_vec;
  logic                  ack_q, ack_pulse;
  sev_e                  sev;
  warn_state_e           state_q, state_d;
  logic                  sil_q, sil_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_q, blink_d;

  assign raw_vec = {ack_btn, coolant_low, coolant_temp_high, oil_low, oil_temp_high};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_db
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw_vec[g]),
      .db_o  (db_vec[g])
    );
  end

  assign flags_db  = db_vec[NUM_FLAGS-1:0];
  assign ack_pulse = db_vec[IDX_ACK] & ~ack_q;
  assign sev       = classify(flags_db, RED_MASK);

  always_comb begin
    state_d = state_q;
    sil_d   = sil_q;
    case (state_q)
      ST_OK: begin
        if (sev == SEV_RED)          state_d = ST_ALARM;
        else if (sev == SEV_CAUTION) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (sev == SEV_RED)       state_d = ST_ALARM;
        else if (sev == SEV_NONE) state_d = ST_OK;
      end
      ST_ALARM: begin
        if (ack_pulse)      sil_d   = 1'b1;
        if (sev != SEV_RED) state_d = ST_HELD;
      end
      ST_HELD: begin
        // Re-escalation outranks an acknowledge landing in the same cycle.
        if (sev == SEV_RED) state_d = ST_ALARM;
        else if (ack_pulse) state_d = (sev == SEV_CAUTION) ? ST_WARN : ST_OK;
      end
      default: state_d = ST_OK;
    endcase
    if (state_d == ST_ALARM && state_q != ST_ALARM) sil_d = 1'b0;
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_q == ST_ALARM && !sil_q) begin
      blink_d = blink_q;
      if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) blink_d     = ~blink_q;
      else                                           blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OK;
      sil_q       <= 1'b0;
      ack_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sil_q       <= sil_d;
      ack_q       <= db_vec[IDX_ACK];
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Gate the registered toggle so the output drops the same cycle the alarm is silenced or left.
  assign alarm_blink = blink_q & (state_q == ST_ALARM) & ~sil_q;
  assign led_green   = (state_q == ST_OK);
  assign led_yellow  = (state_q == ST_WARN);
  assign led_red     = (state_q == ST_ALARM) || (state_q == ST_HELD);
  assign warn_state  = state_q;

`ifdef FAULT_LOG_EN
  logic [NUM_FLAGS-1:0] log_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             log_q <= '0;
    else if (ack_pulse && state_q == ST_OK) log_q <= flags_db;
    else                                    log_q <= log_q | flags_db;
  end

  assign fault_log = log_q;
`else
  assign fault_log = '0;
`endif

endmodule

// File: tb/tb_engine_warning_ctrl.sv
// Randomised bench for engine_warning_ctrl with a cycle-level behavioural model,
// an every-cycle output compare and directed literal checks of the key scenarios.
module tb_engine_warning_ctrl;
  localparam int          DC = 4;
  localparam int          BH = 8;
  localparam logic [15:0] RM = 16'hF0A8;

  logic       clk, rst_n;
  logic [4:0] rin;  // {ack, coolant_low, coolant_temp_high, oil_low, oil_temp_high}
  logic       led_green, led_yellow, led_red, alarm_blink;
  logic [1:0] warn_state;
  logic [3:0] flags_db, fault_log;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  engine_warning_ctrl #(
    .DEBOUNCE_CYCLES(DC), .BLINK_HALF_PERIOD(BH), .RED_MASK(RM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coolant_low(rin[3]), .coolant_temp_high(rin[2]), .oil_low(rin[1]),
    .oil_temp_high(rin[0]), .ack_btn(rin[4]),
    .led_green(led_green), .led_yellow(led_yellow), .led_red(led_red),
    .alarm_blink(alarm_blink), .warn_state(warn_state),
    .flags_db(flags_db), .fault_log(fault_log)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: raw -> 2-cycle delay -> "last DC samples all disagree" flip rule,
  // then the severity/state rules, blink as (cycles in unsilenced alarm / BH) parity.
  bit [4:0] m_s1, m_s2, m_db;
  bit [4:0] hist [DC];
  bit       m_ack_prev, m_sil, all_diff, ackp, red, caution;
  int       m_state, ns, run;
  bit [3:0] m_log, f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int k = 0; k < DC; k++) hist[k] = '0;
      m_ack_prev = 1'b0; m_sil = 1'b0; m_state = 0; run = 0; m_log = '0;
    end else begin
      f       = m_db[3:0];
      ackp    = m_db[4] && !m_ack_prev;
      red     = RM[f];
      caution = (f != 0) && !red;
      if (m_state == 2 && !m_sil) run++;
      else run = 0;
      ns = m_state;
      case (m_state)
        0: if (red) ns = 2; else if (caution) ns = 1;
        1: if (red) ns = 2; else if (f == 0) ns = 0;
        2: begin if (ackp) m_sil = 1'b1; if (!red) ns = 3; end
        default: if (red) ns = 2; else if (ackp) ns = caution ? 1 : 0;
      endcase
      if (ns == 2 && m_state != 2) m_sil = 1'b0;
`ifdef FAULT_LOG_EN
      if (ackp && m_state == 0) m_log = f;
      else m_log = m_log | f;
`endif
      m_state    = ns;
      m_ack_prev = m_db[4];
      for (int k = DC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = m_s2;
      for (int i = 0; i < 5; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) m_db[i] = ~m_db[i];
      end
      m_s2 = m_s1;
      m_s1 = rin;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_warn_state", int'(warn_state), m_state);
      chk("m_led_green",  int'(led_green),  int'(m_state == 0));
      chk("m_led_yellow", int'(led_yellow), int'(m_state == 1));
      chk("m_led_red",    int'(led_red),    int'(m_state >= 2));
      chk("m_blink",      int'(alarm_blink),
          (m_state == 2 && !m_sil) ? ((run / BH) % 2) : 0);
      chk("m_flags_db",   int'(flags_db),   int'(m_db[3:0]));
      chk("m_fault_log",  int'(fault_log),  int'(m_log));
      chk("m_one_hot",    int'(led_green) + int'(led_yellow) + int'(led_red), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int idx;

  initial begin
    rin = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    cyc(2);
    chk("rst_green", int'(led_green), 1);
    chk("rst_state", int'(warn_state), 0);
    chk("rst_outs",  int'({led_yellow, led_red, alarm_blink, flags_db, fault_log}), 0);
    rst_n = 1'b1;
    cyc(2);

    // glitch shorter than the debounce window
    rin[1] = 1'b1; cyc(3); rin[1] = 1'b0; cyc(10);
    chk("glitch_flags", int'(flags_db), 0);
    chk("glitch_green", int'(led_green), 1);

    // single caution flag
    rin[1] = 1'b1;
    cyc(5); chk("t1_flags_early", int'(flags_db), 0);
    cyc(1); chk("t1_flags", int'(flags_db), 2); chk("t1_state_lag", int'(warn_state), 0);
    cyc(1); chk("t1_state", int'(warn_state), 1); chk("t1_yellow", int'(led_yellow), 1);
    rin[1] = 1'b0; cyc(7);
    chk("t1_back_ok", int'(led_green), 1);

    // red combination, blink cadence, silence
    rin[1:0] = 2'b11;
    cyc(7); chk("t3_alarm", int'(warn_state), 2); chk("t3_red", int'(led_red), 1);
    chk("t3_blink0", int'(alarm_blink), 0);
    cyc(7); chk("t3_blink_pre", int'(alarm_blink), 0);
    cyc(1); chk("t3_blink_on", int'(alarm_blink), 1);
    cyc(8); chk("t3_blink_off", int'(alarm_blink), 0);
    rin[4] = 1'b1;
    cyc(7); chk("t3_sil_blink", int'(alarm_blink), 0); chk("t3_sil_red", int'(led_red), 1);
    cyc(8); chk("t3_sil_hold", int'(alarm_blink), 0); chk("t3_sil_state", int'(warn_state), 2);
    rin[4] = 1'b0; cyc(8);

    // held, acknowledge, re-escalation racing an acknowledge
    rin[1:0] = 2'b00;
    cyc(7); chk("t4_held", int'(warn_state), 3); chk("t4_held_red", int'(led_red), 1);
    rin[4] = 1'b1;
    cyc(7); chk("t4_ack_ok", int'(warn_state), 0); chk("t4_green", int'(led_green), 1);
    rin[4] = 1'b0; cyc(8);
    rin[1:0] = 2'b11; cyc(7);
    rin[1:0] = 2'b00; cyc(7); chk("t4_held2", int'(warn_state), 3);
    rin[1:0] = 2'b11; rin[4] = 1'b1;
    cyc(7); chk("t4_realarm", int'(warn_state), 2); chk("t4_blink_rst", int'(alarm_blink), 0);
    cyc(8); chk("t4_blink_restart", int'(alarm_blink), 1);

    // async reset in the middle of blinking
    cyc(3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t5_green", int'(led_green), 1);
    chk("t5_blink", int'(alarm_blink), 0);
    chk("t5_state", int'(warn_state), 0);
    chk("t5_flags", int'(flags_db), 0);
    chk("t5_red",   int'(led_red), 0);
    rin = '0;
    cyc(2); rst_n = 1'b1; cyc(2);

    // sticky fault log
    rin[3] = 1'b1; cyc(8); rin[3] = 1'b0; cyc(10);
    chk("t6_state_ok", int'(warn_state), 0);
`ifdef FAULT_LOG_EN
    chk("t6_log_set", int'(fault_log), 8);
`else
    chk("t6_log_off", int'(fault_log), 0);
`endif
    rin[4] = 1'b1; cyc(7);
    chk("t6_log_clr", int'(fault_log), 0);
    rin[4] = 1'b0; cyc(8);

    // random soak against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 4);
        rin[idx] = ~rin[idx];
      end
    end
    cyc(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
